// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multicycle MIPS datapath. It decodes Opcode/Funct
// from the held instruction register, steps the instruction through its
// phases, and drives the ALU control code, the operand selects and every
// datapath write strobe. The ALU Zero flag resolves branches in BRANCH.
//
// Optional feature: define MCTRL_BNE_EN to decode opcode 000101 (bne) into
// BRANCH with an inverted Zero qualification. Without it, bne is illegal.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Opcode     in   IR[31:26]
//   Funct      in   IR[5:0]
//   Zero       in   ALU zero flag, valid in the current cycle
//   PCWrite    out  PC load strobe (unconditional and branch writes combined)
//   IorD       out  memory address select: 0=PC, 1=ALUOut
//   MemRead    out  memory read strobe
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load strobe
//   MemtoReg   out  register write-data select: 0=ALUOut, 1=MDR
//   RegDst     out  destination register select: 0=rt, 1=rd
//   RegWrite   out  register file write strobe
//   ALUSrcA    out  ALU operand A select: 0=PC, 1=A
//   ALUSrcB    out  ALU operand B select: 00=B, 01=4, 10=ext imm, 11=sext imm<<2
//   ZeroExt    out  immediate extension: 1=zero-extend, 0=sign-extend
//   PCSource   out  PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   ALUControl out  operation code to the ALU
//   Illegal    out  one-cycle pulse on an unsupported opcode or funct
//   State      out  current state, debug only
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ZeroExt,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALUControl,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
`ifdef MCTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t     r_state;
    state_t     w_next;

    logic       w_pcWrite;
    logic       w_iorD;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_memtoReg;
    logic       w_regDst;
    logic       w_regWrite;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic       w_zeroExt;
    logic [1:0] w_pcSource;
    logic [3:0] w_aluControl;
    logic       w_illegal;
    logic [3:0] w_fnAlu;
    logic       w_fnValid;
    logic [3:0] w_immAlu;
    logic       w_immZext;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type funct map, shared by EXEC for both the ALU code and the
    // legality check.
    always_comb begin
        w_fnAlu   = ALU_ADD;
        w_fnValid = 1'b1;
        case (Funct)
            FN_ADD:  w_fnAlu = ALU_ADD;
            FN_SUB:  w_fnAlu = ALU_SUB;
            FN_AND:  w_fnAlu = ALU_AND;
            FN_OR:   w_fnAlu = ALU_OR;
            FN_XOR:  w_fnAlu = ALU_XOR;
            FN_NOR:  w_fnAlu = ALU_NOR;
            FN_SLT:  w_fnAlu = ALU_SLT;
            default: w_fnValid = 1'b0;
        endcase
    end

    // I-type immediate map. IEXEC and IWB both use it, which is how IWB
    // holds the IEXEC ALU settings while the IR stays stable.
    always_comb begin
        w_immAlu  = ALU_ADD;
        w_immZext = 1'b0;
        case (Opcode)
            OP_ANDI: begin w_immAlu = ALU_AND; w_immZext = 1'b1; end
            OP_ORI:  begin w_immAlu = ALU_OR;  w_immZext = 1'b1; end
            OP_SLTI: w_immAlu = ALU_SLT;
            default: w_immAlu = ALU_ADD;
        endcase
    end

    // Next-state and Moore outputs. Only PCWrite in BRANCH looks at Zero.
    always_comb begin
        w_next       = FETCH;
        w_pcWrite    = 1'b0;
        w_iorD       = 1'b0;
        w_memRead    = 1'b0;
        w_memWrite   = 1'b0;
        w_irWrite    = 1'b0;
        w_memtoReg   = 1'b0;
        w_regDst     = 1'b0;
        w_regWrite   = 1'b0;
        w_aluSrcA    = 1'b0;
        w_aluSrcB    = 2'b00;
        w_zeroExt    = 1'b0;
        w_pcSource   = 2'b00;
        w_aluControl = 4'b0000;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                w_memRead    = 1'b1;
                w_irWrite    = 1'b1;
                w_aluSrcB    = 2'b01;
                w_aluControl = ALU_ADD;
                w_pcSource   = 2'b00;
                w_pcWrite    = 1'b1;
                w_next       = DECODE;
            end
            DECODE: begin
                w_aluSrcB    = 2'b11;
                w_aluControl = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW:                      w_next = MEMADR;
                    OP_R:                              w_next = EXEC;
                    OP_BEQ:                            w_next = BRANCH;
`ifdef MCTRL_BNE_EN
                    OP_BNE:                            w_next = BRANCH;
`endif
                    OP_J:                              w_next = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = IEXEC;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                w_aluSrcA    = 1'b1;
                w_aluSrcB    = 2'b10;
                w_aluControl = ALU_ADD;
                w_next       = (Opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                w_next    = MEMWB;
            end
            MEMWB: begin
                w_regWrite = 1'b1;
                w_memtoReg = 1'b1;
                w_next     = FETCH;
            end
            MEMWR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
                w_next     = FETCH;
            end
            EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b00;
                if (w_fnValid) begin
                    w_aluControl = w_fnAlu;
                    w_next       = RWB;
                end else begin
                    w_aluControl = ALU_ADD;
                    w_illegal    = 1'b1;
                    w_next       = FETCH;
                end
            end
            RWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
                w_next     = FETCH;
            end
            BRANCH: begin
                w_aluSrcA    = 1'b1;
                w_aluSrcB    = 2'b00;
                w_aluControl = ALU_SUB;
                w_pcSource   = 2'b01;
`ifdef MCTRL_BNE_EN
                w_pcWrite    = (Opcode == OP_BNE) ? ~Zero : Zero;
`else
                w_pcWrite    = Zero;
`endif
                w_next       = FETCH;
            end
            JUMP: begin
                w_pcSource = 2'b10;
                w_pcWrite  = 1'b1;
                w_next     = FETCH;
            end
            IEXEC: begin
                w_aluSrcA    = 1'b1;
                w_aluSrcB    = 2'b10;
                w_aluControl = w_immAlu;
                w_zeroExt    = w_immZext;
                w_next       = IWB;
            end
            IWB: begin
                w_regWrite   = 1'b1;
                w_aluSrcA    = 1'b1;
                w_aluSrcB    = 2'b10;
                w_aluControl = w_immAlu;
                w_zeroExt    = w_immZext;
                w_next       = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    // Outputs are masked by Reset_n so an aborted instruction's strobes
    // vanish the moment reset asserts, not at the next edge.
    assign PCWrite    = Reset_n & w_pcWrite;
    assign IorD       = Reset_n & w_iorD;
    assign MemRead    = Reset_n & w_memRead;
    assign MemWrite   = Reset_n & w_memWrite;
    assign IRWrite    = Reset_n & w_irWrite;
    assign MemtoReg   = Reset_n & w_memtoReg;
    assign RegDst     = Reset_n & w_regDst;
    assign RegWrite   = Reset_n & w_regWrite;
    assign ALUSrcA    = Reset_n & w_aluSrcA;
    assign ALUSrcB    = Reset_n ? w_aluSrcB : 2'b00;
    assign ZeroExt    = Reset_n & w_zeroExt;
    assign PCSource   = Reset_n ? w_pcSource : 2'b00;
    assign ALUControl = Reset_n ? w_aluControl : 4'b0000;
    assign Illegal    = Reset_n & w_illegal;
    assign State      = Reset_n ? STATE_W'(r_state) : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed testbench for mips_multicycle_ctrl. Every output is packed into a
// single observation vector {State, 9 strobes, ALUSrcB, ZeroExt, PCSource,
// ALUControl, Illegal} and compared against hand-written per-state vectors.
// Strobe order: PCWrite IorD MemRead MemWrite IRWrite MemtoReg RegDst
// RegWrite ALUSrcA.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic       Clock;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, Illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUControl;
    logic [3:0] State;

    int nChecks = 0;
    int nPass   = 0;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .PCSource(PCSource),
        .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [22:0] obs;
    assign obs = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource,
                  ALUControl, Illegal};

    localparam logic [22:0] V_ZERO   = 23'd0;
    localparam logic [22:0] V_FETCH  = {4'd0, 9'b101010000, 2'b01, 1'b0, 2'b00, 4'b0010, 1'b0};
    localparam logic [22:0] V_DECODE = {4'd1, 9'b000000000, 2'b11, 1'b0, 2'b00, 4'b0010, 1'b0};
    localparam logic [22:0] V_DECILL = {4'd1, 9'b000000000, 2'b11, 1'b0, 2'b00, 4'b0010, 1'b1};
    localparam logic [22:0] V_MEMADR = {4'd2, 9'b000000001, 2'b10, 1'b0, 2'b00, 4'b0010, 1'b0};
    localparam logic [22:0] V_MEMRD  = {4'd3, 9'b011000000, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0};
    localparam logic [22:0] V_MEMWB  = {4'd4, 9'b000001010, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0};
    localparam logic [22:0] V_MEMWR  = {4'd5, 9'b010100000, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0};
    localparam logic [22:0] V_RWB    = {4'd7, 9'b000000110, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0};
    localparam logic [22:0] V_JUMP   = {4'd9, 9'b100000000, 2'b00, 1'b0, 2'b10, 4'b0000, 1'b0};
    localparam logic [22:0] V_BRT    = {4'd8, 9'b100000001, 2'b00, 1'b0, 2'b01, 4'b0110, 1'b0};
    localparam logic [22:0] V_BRNT   = {4'd8, 9'b000000001, 2'b00, 1'b0, 2'b01, 4'b0110, 1'b0};
    localparam logic [22:0] V_EXILL  = {4'd6, 9'b000000001, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b1};

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        nChecks++;
        if (obs !== V_ZERO) $display("[TB] FAIL reset_hold got %h want %h", obs, V_ZERO);
        else nPass++;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        nChecks++;
        if (obs !== V_FETCH) $display("[TB] FAIL reset_release got %h want %h", obs, V_FETCH);
        else nPass++;
    endtask

    task automatic test_lw();
        logic [22:0] exp [6];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
        Opcode = 6'b100011; Funct = 6'b000000; Zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nChecks++;
            if (obs !== exp[i]) $display("[TB] FAIL lw step %0d got %h want %h", i, obs, exp[i]);
            else nPass++;
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [22:0] exp [5];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
        Opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if (obs !== exp[i]) $display("[TB] FAIL sw step %0d got %h want %h", i, obs, exp[i]);
            else nPass++;
            if (i < 4) tick();
        end
    endtask

    task automatic test_reset_mid_lw();
        Opcode = 6'b100011;
        repeat (3) tick();
        nChecks++;
        if (obs !== V_MEMRD) $display("[TB] FAIL abort_pre got %h want %h", obs, V_MEMRD);
        else nPass++;
        Reset_n = 1'b0;
        #1;
        nChecks++;
        if (obs !== V_ZERO) $display("[TB] FAIL abort_immediate got %h want %h", obs, V_ZERO);
        else nPass++;
        tick();
        nChecks++;
        if (obs !== V_ZERO) $display("[TB] FAIL abort_held got %h want %h", obs, V_ZERO);
        else nPass++;
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        nChecks++;
        if (obs !== V_FETCH) $display("[TB] FAIL abort_release got %h want %h", obs, V_FETCH);
        else nPass++;
        tick();
        nChecks++;
        if (obs !== V_DECODE) $display("[TB] FAIL abort_first_edge got %h want %h", obs, V_DECODE);
        else nPass++;
        repeat (4) tick();
        nChecks++;
        if (obs !== V_FETCH) $display("[TB] FAIL abort_recover got %h want %h", obs, V_FETCH);
        else nPass++;
    endtask

    task automatic test_rtype();
        logic [5:0]  fn  [3];
        logic [3:0]  alu [3];
        logic [22:0] exp [5];
        fn  = '{6'b100111, 6'b100000, 6'b101010};
        alu = '{4'b1100, 4'b0010, 4'b0111};
        Opcode = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            Funct = fn[k];
            exp = '{V_FETCH, V_DECODE,
                    {4'd6, 9'b000000001, 2'b00, 1'b0, 2'b00, alu[k], 1'b0},
                    V_RWB, V_FETCH};
            for (int i = 0; i < 5; i++) begin
                nChecks++;
                if (obs !== exp[i])
                    $display("[TB] FAIL rtype fn=%b step %0d got %h want %h", fn[k], i, obs, exp[i]);
                else nPass++;
                if (i < 4) tick();
            end
        end
    endtask

    task automatic test_beq();
        logic        zv  [2];
        logic [22:0] exp [4];
        zv = '{1'b1, 1'b0};
        Opcode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            Zero = zv[k];
            exp = '{V_FETCH, V_DECODE, zv[k] ? V_BRT : V_BRNT, V_FETCH};
            for (int i = 0; i < 4; i++) begin
                nChecks++;
                if (obs !== exp[i])
                    $display("[TB] FAIL beq zero=%0d step %0d got %h want %h", zv[k], i, obs, exp[i]);
                else nPass++;
                if (i < 3) tick();
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [22:0] exp [4];
        exp = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
        Opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (obs !== exp[i]) $display("[TB] FAIL jump step %0d got %h want %h", i, obs, exp[i]);
            else nPass++;
            if (i < 3) tick();
        end
    endtask

    task automatic test_itype();
        logic [5:0]  op  [4];
        logic [3:0]  alu [4];
        logic        ze  [4];
        logic [22:0] exp [5];
        op  = '{6'b001100, 6'b001000, 6'b001101, 6'b001010};
        alu = '{4'b0000,   4'b0010,   4'b0001,   4'b0111};
        ze  = '{1'b1,      1'b0,      1'b1,      1'b0};
        for (int k = 0; k < 4; k++) begin
            Opcode = op[k];
            exp = '{V_FETCH, V_DECODE,
                    {4'd10, 9'b000000001, 2'b10, ze[k], 2'b00, alu[k], 1'b0},
                    {4'd11, 9'b000000011, 2'b10, ze[k], 2'b00, alu[k], 1'b0},
                    V_FETCH};
            for (int i = 0; i < 5; i++) begin
                nChecks++;
                if (obs !== exp[i])
                    $display("[TB] FAIL itype op=%b step %0d got %h want %h", op[k], i, obs, exp[i]);
                else nPass++;
                if (i < 4) tick();
            end
        end
    endtask

    task automatic test_illegal();
        logic [22:0] expOp [3];
        logic [22:0] expFn [4];
        expOp = '{V_FETCH, V_DECILL, V_FETCH};
        Opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if (obs !== expOp[i]) $display("[TB] FAIL illegal_op step %0d got %h want %h", i, obs, expOp[i]);
            else nPass++;
            if (i < 2) tick();
        end
        expFn = '{V_FETCH, V_DECODE, V_EXILL, V_FETCH};
        Opcode = 6'b000000;
        Funct  = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (obs !== expFn[i]) $display("[TB] FAIL illegal_fn step %0d got %h want %h", i, obs, expFn[i]);
            else nPass++;
            if (i < 3) tick();
        end
    endtask

    task automatic test_bne();
        Opcode = 6'b000101;
        Zero   = 1'b0;
        tick();
        nChecks++;
`ifdef MCTRL_BNE_EN
        if (obs !== V_DECODE) $display("[TB] FAIL bne_decode got %h want %h", obs, V_DECODE);
        else nPass++;
        tick();
        nChecks++;
        if (obs !== V_BRT) $display("[TB] FAIL bne_branch got %h want %h", obs, V_BRT);
        else nPass++;
`else
        if (obs !== V_DECILL) $display("[TB] FAIL bne_illegal got %h want %h", obs, V_DECILL);
        else nPass++;
`endif
        tick();
        nChecks++;
        if (obs !== V_FETCH) $display("[TB] FAIL bne_return got %h want %h", obs, V_FETCH);
        else nPass++;
    endtask

    initial begin
        Reset_n = 1'b0;
        Opcode  = 6'b000000;
        Funct   = 6'b000000;
        Zero    = 1'b0;
        #1;
        test_reset();
        test_lw();
        test_sw();
        test_reset_mid_lw();
        test_rtype();
        test_beq();
        test_jump();
        test_itype();
        test_illegal();
        test_bne();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath; it is the driving end of the ALU interface.
- Decodes Opcode/Funct and sequences instruction phases.
- Drives the 4-bit ALU Control code, operand selects and all datapath write strobes.
- Samples the ALU Zero flag to resolve branches.

Parameters:
- STATE_W, 4, width of the state register and of the State debug port.

Ports:
- Clock  in  1  system clock. One clock; all state updates on the rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid in the current cycle
- PCWrite  out  1  PC load strobe; unconditional and branch-qualified writes are already combined
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load strobe
- MemtoReg  out  1  register write-data select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register select: 0=rt, 1=rd
- RegWrite  out  1  register file write strobe
- ALUSrcA  out  1  ALU operand A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU operand B select: 00=B, 01=4, 10=ext imm, 11=sext imm<<2
- ZeroExt  out  1  immediate extension: 1=zero-extend, 0=sign-extend
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- ALUControl  out  4  operation code to the ALU
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- State  out  STATE_W  current state, debug only

Behaviour:
- ALUControl codes: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100, xor 1101.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
- Outputs are decoded combinationally from the state register. The only exception is PCWrite in BRANCH, which also depends on Zero.
- Any output not listed for a state is 0 in that state.
- Reset:
  - Reset_n low forces the state to FETCH immediately (asynchronous).
  - While Reset_n is low, every output is 0, including ALUControl and State.
  - The first FETCH cycle runs on the first rising edge after Reset_n deasserts.
  - Reset asserted mid-instruction aborts it; no strobe from the aborted state may be seen once Reset_n is low.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUControl=add, PCSource=00, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcB=11, ALUControl=add (branch-target precompute into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi, andi, ori, slti -> IEXEC
  - any other opcode -> FETCH, with Illegal=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Next MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from the funct map.
  - Unsupported funct: ALUControl=add, Illegal=1, next FETCH (no writeback).
  - Otherwise next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCSource=01, PCWrite=Zero. Next FETCH.
- JUMP: PCSource=10, PCWrite=1. Next FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. Next IWB.
  - addi: ALUControl=add, ZeroExt=0.
  - andi: ALUControl=and, ZeroExt=1.
  - ori: ALUControl=or, ZeroExt=1.
  - slti: ALUControl=slt, ZeroExt=0.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. ALUControl, ALUSrcA, ALUSrcB and ZeroExt hold their IEXEC values. Next FETCH.
- Latency in cycles, FETCH to FETCH: lw 5; sw, R-type and I-type 4; beq and j 3; illegal opcode 2.
- Opcode and Funct must be stable from DECODE until the return to FETCH (IR is held); the FSM does not latch them.
- Unreachable encodings 12-15 go to FETCH on the next edge with all outputs 0.

Optional Feature:
- Macro MCTRL_BNE_EN.
- Defined: opcode 000101 (bne) is decoded to BRANCH. In BRANCH for bne, PCWrite=~Zero; all other BRANCH outputs are identical to beq.
- Undefined: 000101 is illegal (DECODE pulses Illegal and returns to FETCH).

Test Plan:
- Reset_n low mid-MEMRD (lw) -> all outputs 0 at once; after release, State=0 with MemRead=1, IRWrite=1, PCWrite=1, ALUControl=0010.
- lw (100011) -> State sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; IorD=1 in state 3.
- R-type with funct 100111 (nor) -> ALUControl=1100 in EXEC; RegWrite=1 with RegDst=1 in RWB; 4 cycles total.
- beq with Zero=1 then Zero=0 -> PCWrite=1 with PCSource=01 in BRANCH for the first; PCWrite=0 for the second; ALUControl=0110 both times.
- andi (001100) -> ZeroExt=1, ALUControl=0000, ALUSrcB=10 in IEXEC; RegWrite=1 with RegDst=0 in IWB.
- Opcode 111111 and R-type funct 000000 -> Illegal pulses for exactly 1 cycle; no RegWrite, MemWrite or PCWrite beyond FETCH.
